// File: rtl/inst_sram_if.sv
// inst_sram_if: fixed-latency instruction SRAM responder for the naive-mips fetch stage.
// Define INST_BUF_EN to add a one-entry tagged instruction buffer that replays repeated fetches.
module inst_sram_if #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        stall_req_o,
  output logic        sram_en_o,
  output logic [31:0] sram_addr_o,
  input  logic [31:0] sram_rdata_i
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] PHYS_MASK = 32'h1FFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic                buf_hit;
  logic [DATA_W-1:0]   buf_word;

  // Fetch sequencing: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE, or IDLE -> DONE on a buffer hit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    unique case (state_q)
      IDLE: begin
        if (ce_i && !flush_i) begin
          if (buf_hit) begin
            inst_d  = buf_word;
            state_d = DONE;
          end else begin
            addr_d  = pc_i;
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (flush_i || !ce_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          inst_d  = sram_rdata_i;
          state_d = DONE;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
    end
  end

`ifdef INST_BUF_EN
  logic              buf_vld_q, buf_vld_d;
  logic [ADDR_W-1:0] buf_tag_q, buf_tag_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  // Refill on every completed access; any aborted access invalidates the entry.
  always_comb begin
    buf_vld_d  = buf_vld_q;
    buf_tag_d  = buf_tag_q;
    buf_data_d = buf_data_q;
    if (state_q == ACCESS) begin
      if (flush_i || !ce_i) begin
        buf_vld_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        buf_vld_d  = 1'b1;
        buf_tag_d  = addr_q;
        buf_data_d = sram_rdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld_q  <= 1'b0;
      buf_tag_q  <= '0;
      buf_data_q <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      buf_tag_q  <= buf_tag_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign buf_hit  = buf_vld_q && (pc_i == buf_tag_q);
  assign buf_word = buf_data_q;
`else
  assign buf_hit  = 1'b0;
  assign buf_word = '0;
`endif

  // Stall is held low under reset and flush so the PC register can reload freely.
  assign sram_en_o    = (state_q == ACCESS);
  assign sram_addr_o  = sram_en_o ? (addr_q & PHYS_MASK) : '0;
  assign stall_req_o  = !rst && !flush_i &&
                        (((state_q == IDLE) && ce_i) || (state_q == ACCESS));
  assign inst_valid_o = (state_q == DONE) && !flush_i;
  assign inst_o       = inst_q;

endmodule
